alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and result buffer for the shared 8-bit four-function ALU (add, subtract, AND, OR). Each requester issues an opcode and two operands over a valid/ready handshake. The block grants at most one request per cycle, computes the result, and holds it in a per-port response register until that requester accepts it. It sits between the two datapath clients and the single ALU instance, so neither client needs to know the other exists.

## Interface
- WIDTH, 8, operand/result width
- CNT_W, 16, width of completed-operation counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle (combinational)
- req0_op  in  2  port 0 opcode: 00 add, 01 sub, 10 and, 11 or
- req0_a, req0_b  in  WIDTH  port 0 operands
- rsp0_valid  out  1  port 0 result valid
- rsp0_ready  in  1  port 0 consumer accepts result
- rsp0_data  out  WIDTH  port 0 result
- req1_* / rsp1_*  same as port 0, for port 1
- op_count  out  CNT_W  number of accepted requests, wraps modulo 2^CNT_W
- rsp0_zero, rsp1_zero  out  1  result-is-zero flag (only with ALU_ARB_ZFLAG_EN)

## Operation
- Port p is eligible when reqp_valid && (!rspp_valid || rspp_ready): its slot is empty or is being drained this cycle.
- Arbitration state is `last` (1 bit, last granted port).
  - Both ports eligible: grant the port != last.
  - One port eligible: grant it.
  - Neither eligible: no grant; `last` unchanged.
- reqp_ready = grant to p. It is combinational from the valids, the response state and `last`; it never depends on the requester seeing ready first.
- On a grant, the result is computed from the granted port's op/a/b:
  - Results are truncated to WIDTH; carry and borrow are discarded.
  - sub is a - b modulo 2^WIDTH (e.g. 0x00-0x01 = 0xFF).
- On a grant, at the clock edge:
  - rspp_data <= result
  - rspp_valid <= 1
  - last <= p
  - op_count += 1
- A response drains when rspp_valid && rspp_ready. rspp_valid then clears at the edge, unless the same port is granted that cycle, in which case it stays 1 and the data is replaced.
- rspp_data holds stable while rspp_valid=1 && !rspp_ready.
- A non-granted port with valid asserted must hold its request. The block does not capture it.

## Timing
- Reset values:
  - req0_ready=req1_ready=0 during rst
  - rsp0_valid=rsp1_valid=0
  - rsp0_data=rsp1_data=0
  - op_count=0
  - last=1, so port 0 wins the first contended cycle
  - zero flags=0
- Latency: request accepted at edge N → rspp_valid=1 with result after edge N, visible in cycle N+1.
- Throughput: 1 op/cycle total. With both ports eligible every cycle, grants alternate 0,1,0,1…
- A port may issue back-to-back requests every cycle if its consumer holds rspp_ready=1.
- Back-pressure: rspp_valid=1 && rspp_ready=0 → port p is ineligible. The other port receives every grant.
- rst asserted mid-operation: all held results and valid flags are discarded at the next edge. The pending request is not accepted, because req_ready is forced 0 while rst=1.
- op_count wraps from 2^CNT_W-1 to 0 without saturation.

## Configuration
- ALU_ARB_ZFLAG_EN defined: adds rsp0_zero/rsp1_zero ports.
  - Each flag is registered alongside rspp_data and equals (result == 0).
  - Each flag follows the same hold and drain rules as the data.
- ALU_ARB_ZFLAG_EN undefined: the zero-flag ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles with req0_valid=1 → req0_ready=0, both rsp_valid=0, op_count=0. First edge after release grants port 0.
- Single op per opcode on port 0, e.g. a=0x05, b=0x07:
  - op=00 → rsp0_data=0x0C next cycle
  - op=01 → 0xFE
  - op=10 → 0x05
  - op=11 → 0x07
  - add 0xFF+0x01 → 0x00, with rsp0_zero=1 when ALU_ARB_ZFLAG_EN is defined
- Contention: both valid every cycle, both rsp_ready=1, for 6 cycles → grants 0,1,0,1,0,1; op_count=6; each port receives its own operands' results.
- Back-pressure: rsp0_ready=0 with rsp0_valid=1, both requesting for 4 cycles → port 1 granted 4 times; rsp0_data unchanged. Raise rsp0_ready → port 0 granted the same cycle it drains, and rsp0_valid stays 1 with new data.
- Mid-operation reset: grant port 1 and assert rst the next cycle before draining → rsp1_valid=0 after the edge. After release, with both valid, port 0 is granted first.
- Counter wrap (CNT_W=4 build): 17 accepted ops → op_count=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// One requester's view of the shared ALU: request handshake plus buffered response.
// The rsp_zero signal exists only when ALU_ARB_ZFLAG_EN is defined.
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_ARB_ZFLAG_EN
  logic             rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared add/sub/and/or ALU, with a
// per-port response register. Optional zero flags are enabled by ALU_ARB_ZFLAG_EN.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     port0,
  alu_arbiter_if.slave     port1,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  port_t            last;
  port_t            last_next;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_data_q;
  logic [WIDTH-1:0] rsp1_data_q;
`ifdef ALU_ARB_ZFLAG_EN
  logic             rsp0_zero_q;
  logic             rsp1_zero_q;
`endif

  // Reset leaves last on port 1 so port 0 wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT1;
    end else begin
      last <= last_next;
    end
  end

  always_comb begin
    elig0     = port0.req_valid && (!rsp0_valid_q || port0.rsp_ready);
    elig1     = port1.req_valid && (!rsp1_valid_q || port1.rsp_ready);
    grant0    = 1'b0;
    grant1    = 1'b0;
    last_next = last;
    if (!rst) begin
      if (elig0 && elig1) begin
        if (last == PORT1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
    if (grant0) begin
      last_next = PORT0;
    end else if (grant1) begin
      last_next = PORT1;
    end
  end

  always_comb begin
    port0.req_ready = grant0;
    port1.req_ready = grant1;
    port0.rsp_valid = rsp0_valid_q;
    port1.rsp_valid = rsp1_valid_q;
    port0.rsp_data  = rsp0_data_q;
    port1.rsp_data  = rsp1_data_q;
`ifdef ALU_ARB_ZFLAG_EN
    port0.rsp_zero  = rsp0_zero_q;
    port1.rsp_zero  = rsp1_zero_q;
`endif
  end

  // Single ALU instance fed by whichever port holds the grant.
  always_comb begin
    sel_op = grant1 ? port1.req_op : port0.req_op;
    sel_a  = grant1 ? port1.req_a  : port0.req_a;
    sel_b  = grant1 ? port1.req_b  : port0.req_b;
    case (op_t'(sel_op))
      OP_ADD:  result = sel_a + sel_b;
      OP_SUB:  result = sel_a - sel_b;
      OP_AND:  result = sel_a & sel_b;
      default: result = sel_a | sel_b;
    endcase
  end

  // A grant overrides a same-cycle drain, so a draining port can refill at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
`ifdef ALU_ARB_ZFLAG_EN
      rsp0_zero_q  <= 1'b0;
      rsp1_zero_q  <= 1'b0;
`endif
      op_count     <= '0;
    end else begin
      if (grant0) begin
        rsp0_valid_q <= 1'b1;
        rsp0_data_q  <= result;
`ifdef ALU_ARB_ZFLAG_EN
        rsp0_zero_q  <= (result == '0);
`endif
      end else if (port0.rsp_ready) begin
        rsp0_valid_q <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid_q <= 1'b1;
        rsp1_data_q  <= result;
`ifdef ALU_ARB_ZFLAG_EN
        rsp1_zero_q  <= (result == '0);
`endif
      end else if (port1.rsp_ready) begin
        rsp1_valid_q <= 1'b0;
      end
      if (grant0 || grant1) begin
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand-written corner sequences
// and randomized traffic against a behavioural model. Built with CNT_W=4 to reach wrap.
module tb_alu_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] op_count;

  alu_arbiter_if #(.WIDTH(WIDTH)) p0 ();
  alu_arbiter_if #(.WIDTH(WIDTH)) p1 ();

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .port0    (p0),
    .port1    (p1),
    .op_count (op_count)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  int total = 0;
  int bad = 0;
  int m_valid[2];
  int m_data[2];
  int m_last;
  int m_count;
  int last_grant;
  vec_t vecs[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ALU from plain integer arithmetic, results reduced modulo 256.
  function automatic int aluRef(int op, int a, int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int predictGrant();
    bit e0;
    bit e1;
    if (rst) return -1;
    e0 = p0.req_valid && (m_valid[0] == 0 || p0.rsp_ready);
    e1 = p1.req_valid && (m_valid[1] == 0 || p1.rsp_ready);
    if (e0 && e1) return (m_last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    m_valid[0] = 0;
    m_valid[1] = 0;
    m_data[0]  = 0;
    m_data[1]  = 0;
    m_last     = 1;
    m_count    = 0;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setReq(int port, logic v, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    if (port == 0) begin
      p0.req_valid = v;
      p0.req_op    = op;
      p0.req_a     = a;
      p0.req_b     = b;
    end else begin
      p1.req_valid = v;
      p1.req_op    = op;
      p1.req_a     = a;
      p1.req_b     = b;
    end
  endtask

  task automatic compareState();
    checkOutput("rsp0_valid", {31'd0, p0.rsp_valid}, m_valid[0]);
    checkOutput("rsp1_valid", {31'd0, p1.rsp_valid}, m_valid[1]);
    if (m_valid[0] != 0) begin
      checkOutput("rsp0_data", {24'd0, p0.rsp_data}, m_data[0]);
`ifdef ALU_ARB_ZFLAG_EN
      checkOutput("rsp0_zero", {31'd0, p0.rsp_zero}, (m_data[0] == 0));
`endif
    end
    if (m_valid[1] != 0) begin
      checkOutput("rsp1_data", {24'd0, p1.rsp_data}, m_data[1]);
`ifdef ALU_ARB_ZFLAG_EN
      checkOutput("rsp1_zero", {31'd0, p1.rsp_zero}, (m_data[1] == 0));
`endif
    end
    checkOutput("op_count", {{(32-CNT_W){1'b0}}, op_count}, m_count);
  endtask

  // One clock cycle: readies checked on the falling edge, registers after the rising edge.
  task automatic applyStimulus();
    int g;
    int op;
    int a;
    int b;
    bit rr0;
    bit rr1;
    bit rst_s;
    op = 0;
    a  = 0;
    b  = 0;
    @(negedge clk);
    g = predictGrant();
    checkOutput("req0_ready", {31'd0, p0.req_ready}, (g == 0));
    checkOutput("req1_ready", {31'd0, p1.req_ready}, (g == 1));
    if (g == 0) begin
      op = p0.req_op; a = p0.req_a; b = p0.req_b;
    end else if (g == 1) begin
      op = p1.req_op; a = p1.req_a; b = p1.req_b;
    end
    rr0   = p0.rsp_ready;
    rr1   = p1.rsp_ready;
    rst_s = rst;
    @(posedge clk);
    if (rst_s) begin
      modelReset();
    end else begin
      if (m_valid[0] != 0 && rr0) m_valid[0] = 0;
      if (m_valid[1] != 0 && rr1) m_valid[1] = 0;
      if (g >= 0) begin
        m_valid[g] = 1;
        m_data[g]  = aluRef(op, a, b);
        m_last     = g;
        m_count    = (m_count + 1) % (1 << CNT_W);
      end
    end
    last_grant = g;
    #1;
    compareState();
  endtask

  task automatic doReset();
    rst = 1'b1;
    setReq(0, 1'b0, 2'd0, 8'd0, 8'd0);
    setReq(1, 1'b0, 2'd0, 8'd0, 8'd0);
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    bit hold0;
    bit hold1;

    vecs[0] = '{2'd0, 8'h05, 8'h07, 8'h0C, 1'b0};
    vecs[1] = '{2'd1, 8'h05, 8'h07, 8'hFE, 1'b0};
    vecs[2] = '{2'd2, 8'h05, 8'h07, 8'h05, 1'b0};
    vecs[3] = '{2'd3, 8'h05, 8'h07, 8'h07, 1'b0};
    vecs[4] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[5] = '{2'd1, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[6] = '{2'd2, 8'hA5, 8'h5A, 8'h00, 1'b1};
    vecs[7] = '{2'd3, 8'h80, 8'h01, 8'h81, 1'b0};

    modelReset();
    last_grant = -1;
    rst = 1'b1;
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    setReq(0, 1'b1, 2'd0, 8'h01, 8'h02);
    setReq(1, 1'b0, 2'd0, 8'h00, 8'h00);

    // Reset held two cycles with a request pending on port 0.
    applyStimulus();
    applyStimulus();
    checkOutput("reset_data0", {24'd0, p0.rsp_data}, 32'd0);
    checkOutput("reset_data1", {24'd0, p1.rsp_data}, 32'd0);
`ifdef ALU_ARB_ZFLAG_EN
    checkOutput("reset_zero0", {31'd0, p0.rsp_zero}, 32'd0);
    checkOutput("reset_zero1", {31'd0, p1.rsp_zero}, 32'd0);
`endif
    rst = 1'b0;
    setReq(1, 1'b1, 2'd0, 8'h03, 8'h04);
    applyStimulus();
    checkOutput("first_grant", last_grant, 32'd0);

    // Directed opcode table on port 0.
    doReset();
    for (int i = 0; i < 8; i++) begin
      setReq(0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      applyStimulus();
      checkOutput("table_grant", last_grant, 32'd0);
      checkOutput("table_data", {24'd0, p0.rsp_data}, {24'd0, vecs[i].exp_data});
`ifdef ALU_ARB_ZFLAG_EN
      checkOutput("table_zero", {31'd0, p0.rsp_zero}, {31'd0, vecs[i].exp_zero});
`endif
    end

    // Contention: both ports request every cycle, grants must alternate.
    doReset();
    setReq(0, 1'b1, 2'd0, 8'h10, 8'h01);
    setReq(1, 1'b1, 2'd1, 8'h40, 8'h02);
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("contend_grant", last_grant, i % 2);
      if (last_grant == 0) setReq(0, 1'b1, 2'd0, 8'(16 + i), 8'h01);
      if (last_grant == 1) setReq(1, 1'b1, 2'd1, 8'(64 + i), 8'h02);
    end
    checkOutput("contend_count", {{(32-CNT_W){1'b0}}, op_count}, 32'd6);

    // Back-pressure on port 0 hands every grant to port 1.
    doReset();
    setReq(0, 1'b1, 2'd0, 8'h11, 8'h22);
    applyStimulus();
    checkOutput("bp_first", {24'd0, p0.rsp_data}, 32'h33);
    p0.rsp_ready = 1'b0;
    setReq(0, 1'b1, 2'd3, 8'h0F, 8'hF0);
    for (int i = 0; i < 4; i++) begin
      setReq(1, 1'b1, 2'd0, 8'(i), 8'h01);
      applyStimulus();
      checkOutput("bp_grant", last_grant, 32'd1);
      checkOutput("bp_hold", {24'd0, p0.rsp_data}, 32'h33);
    end
    p0.rsp_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_release_grant", last_grant, 32'd0);
    checkOutput("bp_release_valid", {31'd0, p0.rsp_valid}, 32'd1);
    checkOutput("bp_release_data", {24'd0, p0.rsp_data}, 32'hFF);

    // Reset while port 1 holds an undrained result.
    doReset();
    setReq(1, 1'b1, 2'd2, 8'hF0, 8'h3C);
    p1.rsp_ready = 1'b0;
    applyStimulus();
    checkOutput("mid_grant", last_grant, 32'd1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("mid_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    rst = 1'b0;
    p1.rsp_ready = 1'b1;
    setReq(0, 1'b1, 2'd0, 8'h01, 8'h01);
    applyStimulus();
    checkOutput("mid_after_grant", last_grant, 32'd0);

    // Counter wraps after 2^CNT_W + 1 accepted operations.
    doReset();
    p0.rsp_ready = 1'b1;
    setReq(0, 1'b1, 2'd0, 8'h02, 8'h03);
    for (int i = 0; i < 17; i++) begin
      applyStimulus();
    end
    checkOutput("wrap_count", {{(32-CNT_W){1'b0}}, op_count}, 32'd1);

    // Randomized traffic; an ungranted request is held unchanged.
    doReset();
    for (int i = 0; i < 400; i++) begin
      hold0 = p0.req_valid && (last_grant != 0);
      hold1 = p1.req_valid && (last_grant != 1);
      rst = ($urandom_range(0, 49) == 0);
      if (!hold0) setReq(0, ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (!hold1) setReq(1, ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      p0.rsp_ready = ($urandom_range(0, 3) != 0);
      p1.rsp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
